// File: rtl/alu_mul_sequencer_if.sv
// Pipeline-side bus of the ALU/multiply sequencer: single-cycle execute ops
// plus the iterative multiply handshake.
interface alu_mul_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             ex_valid;
  logic [WIDTH-1:0] ex_in1;
  logic [WIDTH-1:0] ex_in2;
  logic [3:0]       ex_ctrl;
  logic [WIDTH-1:0] ex_out;
  logic             ex_stall;

  logic             mul_start;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  modport master (
    output ex_valid, ex_in1, ex_in2, ex_ctrl, mul_start, mul_a, mul_b,
    input  ex_out, ex_stall, mul_busy, mul_done, mul_hi, mul_lo
  );

  modport slave (
    input  ex_valid, ex_in1, ex_in2, ex_ctrl, mul_start, mul_a, mul_b,
    output ex_out, ex_stall, mul_busy, mul_done, mul_hi, mul_lo
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Arbitrates the shared execute-stage ALU between pipeline ops and a 16-step
// shift-add unsigned multiply; owns the {N,C,Z} flag register.
module alu_mul_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  alu_mul_sequencer_if.slave bus,
  output logic [WIDTH-1:0]  alu_in1,
  output logic [WIDTH-1:0]  alu_in2,
  output logic [3:0]        alu_ctrl,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic [2:0]        alu_flag,
  output logic [2:0]        flags_q
);

  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0010;

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, hi_q, lo_q;
  logic [WIDTH-1:0] prod_hi_q, prod_lo_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] addend;
  logic             carry;
  logic             last_iter;
  logic             done;

  assign addend    = lo_q[0] ? a_q : '0;
  // The ALU's own carry flag is sign-extended, so the adder carry-out is
  // rebuilt from the operand MSBs and the sum MSB.
  assign carry     = (hi_q[WIDTH-1] & addend[WIDTH-1]) |
                     ((hi_q[WIDTH-1] | addend[WIDTH-1]) & ~alu_out[WIDTH-1]);
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  assign done      = (state_q == S_DONE);

  assign bus.mul_busy = (state_q != S_IDLE);
  assign bus.mul_done = done;
  assign bus.mul_hi   = done ? hi_q : prod_hi_q;
  assign bus.mul_lo   = done ? lo_q : prod_lo_q;

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d      = state_q;
    alu_in1      = '0;
    alu_in2      = '0;
    alu_ctrl     = ALU_NOP;
    bus.ex_out   = '0;
    bus.ex_stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        alu_in1    = bus.ex_in1;
        alu_in2    = bus.ex_in2;
        alu_ctrl   = bus.ex_valid ? bus.ex_ctrl : ALU_NOP;
        bus.ex_out = alu_out;
        if (bus.mul_start) state_d = S_ITER;
      end
      S_ITER: begin
        alu_in1      = hi_q;
        alu_in2      = addend;
        alu_ctrl     = ALU_ADD;
        bus.ex_stall = bus.ex_valid;
        if (last_iter) state_d = S_DONE;
      end
      S_DONE: begin
        bus.ex_stall = bus.ex_valid;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
      flags_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (bus.ex_valid && bus.ex_ctrl != ALU_NOP) flags_q <= alu_flag;
          if (bus.mul_start) begin
            a_q   <= bus.mul_a;
            hi_q  <= '0;
            lo_q  <= bus.mul_b;
            cnt_q <= '0;
          end
        end
        S_ITER: begin
          // {HI,LO} <= {carry, sum, LO >> 1}: the sum's LSB shifts into LO.
          hi_q  <= {carry, alu_out[WIDTH-1:1]};
          lo_q  <= {alu_out[0], lo_q[WIDTH-1:1]};
          cnt_q <= cnt_q + CNT_W'(1);
        end
        S_DONE: begin
          prod_hi_q <= hi_q;
          prod_lo_q <= lo_q;
          flags_q   <= {hi_q[WIDTH-1], flags_q[1], ~|{hi_q, lo_q}};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: behavioural ALU, product and flag
// expectations from plain arithmetic, randomized multiplies plus directed cases.
module tb_alu_mul_sequencer;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_mul_sequencer_if #(.WIDTH(W)) bus ();
  logic [W-1:0] alu_in1, alu_in2, alu_out;
  logic [3:0]   alu_ctrl;
  logic [2:0]   alu_flag, flags_q;

  alu_mul_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .alu_in1  (alu_in1),
    .alu_in2  (alu_in2),
    .alu_ctrl (alu_ctrl),
    .alu_out  (alu_out),
    .alu_flag (alu_flag),
    .flags_q  (flags_q)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [2:0] exp_flags;

  // ALU stand-in; its C flag is the result MSB, mimicking a sign-extended carry.
  function automatic logic [W+2:0] alu_model(input logic [3:0] ctrl,
                                             input logic [W-1:0] in1,
                                             input logic [W-1:0] in2);
    logic [W-1:0] r;
    case (ctrl)
      4'b0000: r = '0;
      4'b0010: r = in1 + in2;
      4'b0110: r = in1 - in2;
      4'b0111: r = in2 + W'(1);
      4'b1011: r = in1 << in2[3:0];
      default: r = in1 & in2;
    endcase
    return {r[W-1], r[W-1], (r == '0), r};
  endfunction

  always_comb {alu_flag, alu_out} = alu_model(alu_ctrl, alu_in1, alu_in2);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.ex_valid  = 1'b0;
    bus.ex_in1    = '0;
    bus.ex_in2    = '0;
    bus.ex_ctrl   = 4'b0000;
    bus.mul_start = 1'b0;
    bus.mul_a     = '0;
    bus.mul_b     = '0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    exp_flags = 3'b000;
    n_checks++;
    if (flags_q !== 3'b000) $display("FAIL reset_flags: got %b expected 000", flags_q);
    else n_pass++;
    n_checks++;
    if (bus.mul_busy !== 1'b0 || bus.mul_done !== 1'b0)
      $display("FAIL reset_busy_done: got busy=%b done=%b expected 0 0", bus.mul_busy, bus.mul_done);
    else n_pass++;
    n_checks++;
    if ({bus.mul_hi, bus.mul_lo} !== 32'h0)
      $display("FAIL reset_product: got %h expected 00000000", {bus.mul_hi, bus.mul_lo});
    else n_pass++;
    n_checks++;
    if (bus.ex_stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", bus.ex_stall);
    else n_pass++;
  endtask

  // Starts a multiply in the current IDLE cycle (optionally with a pipeline op
  // alongside, optionally held through the multiply) and checks latency,
  // product, stall behaviour and flags. Returns in the first IDLE cycle.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit ex_on, input bit hold, input logic [3:0] ctrl,
                         input logic [W-1:0] in1, input logic [W-1:0] in2,
                         input bit repulse, input string name);
    logic [2*W-1:0] prod, got;
    logic [2:0]     ef;
    logic [W-1:0]   eo;
    int             busy_cycles, done_at, stall_bad;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    {ef, eo} = alu_model(ctrl, in1, in2);
    bus.mul_start = 1'b1;
    bus.mul_a     = a;
    bus.mul_b     = b;
    bus.ex_valid  = ex_on | hold;
    bus.ex_ctrl   = ctrl;
    bus.ex_in1    = in1;
    bus.ex_in2    = in2;
    #1;
    if (ex_on | hold) begin
      n_checks++;
      if (bus.ex_out !== eo || bus.ex_stall !== 1'b0)
        $display("FAIL %s start_ex: got out=%h stall=%b expected %h 0", name, bus.ex_out, bus.ex_stall, eo);
      else n_pass++;
    end
    tick();
    if ((ex_on | hold) && ctrl != 4'b0000) exp_flags = ef;
    bus.mul_start = 1'b0;
    if (!hold) bus.ex_valid = 1'b0;
    busy_cycles = 0;
    done_at     = 0;
    stall_bad   = 0;
    got         = '0;
    for (int cyc = 1; cyc <= 40 && done_at == 0; cyc++) begin
      if (repulse && cyc == 5) begin
        bus.mul_start = 1'b1;
        bus.mul_a     = ~a;
        bus.mul_b     = b ^ 16'h5A5A;
      end else begin
        bus.mul_start = 1'b0;
      end
      #1;
      if (bus.mul_busy === 1'b1) busy_cycles++;
      if (hold && (bus.ex_stall !== 1'b1 || bus.ex_out !== '0)) stall_bad++;
      if (bus.mul_done === 1'b1) begin
        done_at = cyc;
        got     = {bus.mul_hi, bus.mul_lo};
      end
      tick();
    end
    bus.mul_start = 1'b0;
    n_checks++;
    if (done_at != 17 || busy_cycles != 17)
      $display("FAIL %s latency: got done_at=%0d busy=%0d expected 17 17", name, done_at, busy_cycles);
    else n_pass++;
    n_checks++;
    if (got !== prod) $display("FAIL %s product: got %h expected %h", name, got, prod);
    else n_pass++;
    if (hold) begin
      n_checks++;
      if (stall_bad != 0) $display("FAIL %s stall_hold: got %0d bad cycles expected 0", name, stall_bad);
      else n_pass++;
    end
    exp_flags = {prod[2*W-1], exp_flags[1], (prod == '0)};
    #1;
    n_checks++;
    if (flags_q !== exp_flags) $display("FAIL %s flags: got %b expected %b", name, flags_q, exp_flags);
    else n_pass++;
    n_checks++;
    if (bus.mul_busy !== 1'b0 || bus.mul_done !== 1'b0 || {bus.mul_hi, bus.mul_lo} !== prod)
      $display("FAIL %s idle_hold: got busy=%b done=%b prod=%h expected 0 0 %h",
               name, bus.mul_busy, bus.mul_done, {bus.mul_hi, bus.mul_lo}, prod);
    else n_pass++;
    if (hold) begin
      n_checks++;
      if (bus.ex_out !== eo || bus.ex_stall !== 1'b0)
        $display("FAIL %s resume_ex: got out=%h stall=%b expected %h 0", name, bus.ex_out, bus.ex_stall, eo);
      else n_pass++;
      tick();
      bus.ex_valid = 1'b0;
      if (ctrl != 4'b0000) exp_flags = ef;
      #1;
      n_checks++;
      if (flags_q !== exp_flags) $display("FAIL %s resume_flags: got %b expected %b", name, flags_q, exp_flags);
      else n_pass++;
    end
  endtask

  task automatic test_directed;
    run_mul(16'h0003, 16'h0005, 0, 0, 4'b0000, '0, '0, 0, "mul_3x5");
    run_mul(16'hFFFF, 16'hFFFF, 0, 0, 4'b0000, '0, '0, 0, "mul_ffff");
    run_mul(16'h1234, 16'h0000, 1, 0, 4'b0010, 16'h7FFF, 16'h0001, 0, "mul_zero_add");
    run_mul(16'h0101, 16'h0202, 0, 1, 4'b0111, 16'h0000, 16'h0009, 0, "mul_hold_inc");
  endtask

  task automatic test_random;
    logic [3:0] ops [4];
    ops = '{4'b0010, 4'b0110, 4'b0111, 4'b1011};
    for (int i = 0; i < 8; i++) begin
      run_mul(W'($urandom), W'($urandom), bit'($urandom_range(0, 1)), 0,
              ops[$urandom_range(0, 3)], W'($urandom), W'($urandom),
              bit'($urandom_range(0, 1)), "mul_random");
    end
  endtask

  task automatic test_back_to_back;
    run_mul(16'h8000, 16'h8000, 0, 0, 4'b0000, '0, '0, 0, "b2b_first");
    run_mul(16'h00FF, 16'h0101, 0, 0, 4'b0000, '0, '0, 0, "b2b_second");
  endtask

  task automatic test_repulse;
    run_mul(16'hABCD, 16'h1357, 1, 0, 4'b1011, 16'hC000, 16'h0001, 1, "mul_repulse");
  endtask

  task automatic test_reset_mid;
    int done_seen;
    bus.mul_start = 1'b1;
    bus.mul_a     = 16'h00FF;
    bus.mul_b     = 16'h0F0F;
    tick();
    bus.mul_start = 1'b0;
    repeat (7) tick();
    n_checks++;
    if (bus.mul_busy !== 1'b1) $display("FAIL midrst_busy_before: got %b expected 1", bus.mul_busy);
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_flags = 3'b000;
    n_checks++;
    if (bus.mul_busy !== 1'b0 || bus.mul_done !== 1'b0)
      $display("FAIL midrst_busy_done: got busy=%b done=%b expected 0 0", bus.mul_busy, bus.mul_done);
    else n_pass++;
    n_checks++;
    if ({bus.mul_hi, bus.mul_lo} !== 32'h0 || flags_q !== exp_flags)
      $display("FAIL midrst_cleared: got prod=%h flags=%b expected 00000000 000",
               {bus.mul_hi, bus.mul_lo}, flags_q);
    else n_pass++;
    done_seen = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus.mul_done === 1'b1 || bus.mul_busy === 1'b1) done_seen++;
      tick();
    end
    n_checks++;
    if (done_seen != 0) $display("FAIL midrst_no_done: got %0d active cycles expected 0", done_seen);
    else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_repulse();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
